// File: rtl/cp0_int_seq.sv
// -----------------------------------------------------------------------------
// cp0_int_seq
//
// Interrupt-entry and ERET sequencer for the pipelined MIPS core.
//
// It watches the masked CP0 interrupt request and ERET instructions decoded in
// ID. For an interrupt, it waits for EX/MEM to drain and then enters the
// handler. For an ERET, it returns to EPC. On either path it drives the CP0
// EXL set/clear pair, the pipeline flush/stall lines and the PC redirect.
//
// Optional feature (macro CP0_INT_CNT_EN):
//   When this macro is defined, the int_cnt output and its counter are built.
//   The counter counts taken interrupts and wraps modulo 2^CNT_W.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-low reset
//   int_req      in   CP0 IntReq, already masked by IM/IE/!EXL
//   id_valid     in   ID holds a real (non-bubble) instruction
//   id_eret      in   ID instruction decodes as ERET
//   ex_busy      in   EX holds an unfinished multi-cycle op
//   mem_busy     in   MEM waiting on memory
//   epc          in   CP0 EPC, PC[31:2]
//   cp0_ctrl     out  {ExlSet, ExlClr} to CP0, one-cycle pulses
//   stall_if     out  freeze PC and IF/ID (DRAIN only)
//   flush_if     out  squash IF/ID register
//   flush_id     out  squash ID/EX register
//   pc_redirect  out  PC mux selects redirect_pc
//   redirect_pc  out  redirect target, PC[31:2]; 0 when no redirect
//   in_handler   out  sequencer's EXL mirror
//   int_cnt      out  taken-interrupt count (CP0_INT_CNT_EN only)
//   state_dbg    out  current FSM state (IDLE=0, DRAIN=1, ENTER=2, ERET=3)
//
// Qualifier semantics: id_valid qualifies both int_req and id_eret for the
// purpose of leaving IDLE. There is no back-pressure. A qualified event is
// acted on in the cycle it is seen; otherwise it is simply not consumed.
// In DRAIN, only int_req matters: it is no longer gated by id_valid, because
// the instruction that EPC will capture is already frozen by stall_if.
// -----------------------------------------------------------------------------
module cp0_int_seq #(
  parameter logic [29:0] HANDLER_VEC = 30'h0000_1060,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              int_req,
  input  logic              id_valid,
  input  logic              id_eret,
  input  logic              ex_busy,
  input  logic              mem_busy,
  input  logic [29:0]       epc,
  output logic [1:0]        cp0_ctrl,
  output logic              stall_if,
  output logic              flush_if,
  output logic              flush_id,
  output logic              pc_redirect,
  output logic [29:0]       redirect_pc,
  output logic              in_handler,
`ifdef CP0_INT_CNT_EN
  output logic [CNT_W-1:0]  int_cnt,
`endif
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_ENTER = 2'd2,
    S_ERET  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   exl_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        // An ERET inside the handler wins over a new interrupt. An ERET seen
        // outside the handler is treated as a NOP. An interrupt is taken only
        // when ID holds a real instruction, so that EPC has something
        // meaningful to capture.
        if (id_valid && id_eret && exl_q) begin
          state_d = S_ERET;
        end else if (int_req && id_valid && !exl_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // A request that vanishes while draining is spurious: we return to
        // IDLE without touching CP0. The drain has no cycle limit.
        if (!int_req) begin
          state_d = S_IDLE;
        end else if (!ex_busy && !mem_busy) begin
          state_d = S_ENTER;
        end
      end
      S_ENTER: state_d = S_IDLE;
      S_ERET:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (Moore, from registered state)
  // ---------------------------------------------------------------------------
  always_comb begin
    cp0_ctrl    = 2'b00;
    stall_if    = 1'b0;
    flush_if    = 1'b0;
    flush_id    = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = 30'd0;
    case (state_q)
      S_DRAIN: begin
        stall_if = 1'b1;
      end
      S_ENTER: begin
        // The flush dominates, so stall_if is deliberately released here.
        cp0_ctrl    = 2'b10;
        flush_if    = 1'b1;
        flush_id    = 1'b1;
        pc_redirect = 1'b1;
        redirect_pc = HANDLER_VEC;
      end
      S_ERET: begin
        // ERET itself sits in ID. It is squashed by the IF/ID flush alone;
        // ID/EX already holds the older instruction, which must complete.
        cp0_ctrl    = 2'b01;
        flush_if    = 1'b1;
        pc_redirect = 1'b1;
        redirect_pc = epc;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // EXL mirror: set on handler entry, cleared on ERET. This mirror (not
  // int_req) is what blocks nested entry.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exl_q <= 1'b0;
    end else if (state_q == S_ENTER) begin
      exl_q <= 1'b1;
    end else if (state_q == S_ERET) begin
      exl_q <= 1'b0;
    end
  end

  assign in_handler = exl_q;
  assign state_dbg  = state_q;

`ifdef CP0_INT_CNT_EN
  // ---------------------------------------------------------------------------
  // Taken-interrupt counter: exactly one increment per ENTER cycle. It wraps
  // naturally at 2^CNT_W.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (state_q == S_ENTER) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign int_cnt = cnt_q;
`endif

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  // ExlSet and ExlClr are mutually exclusive.
  a_ctrl_onehot: assert property (@(posedge clk) disable iff (!rst)
    cp0_ctrl != 2'b11);

  // No redirect means a zero redirect target.
  a_redirect_zero: assert property (@(posedge clk) disable iff (!rst)
    !pc_redirect |-> (redirect_pc == 30'd0));

  // Stalling and flushing never overlap.
  a_stall_flush: assert property (@(posedge clk) disable iff (!rst)
    stall_if |-> !(flush_if || flush_id));

  // A zero-width counter would be meaningless.
  a_cnt_w: assert property (@(posedge clk) CNT_W >= 1);

endmodule

// File: tb/tb_cp0_int_seq.sv
// -----------------------------------------------------------------------------
// tb_cp0_int_seq
//
// This bench drives a set of directed scenarios, followed by a randomized run.
// The randomized run is compared against an event-level reference model.
// -----------------------------------------------------------------------------
module tb_cp0_int_seq;

  localparam logic [29:0] HVEC = 30'h0000_1060;
  localparam int          CW   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        int_req = 1'b0;
  logic        id_valid = 1'b0;
  logic        id_eret = 1'b0;
  logic        ex_busy = 1'b0;
  logic        mem_busy = 1'b0;
  logic [29:0] epc = 30'd0;
  logic [1:0]  cp0_ctrl;
  logic        stall_if;
  logic        flush_if;
  logic        flush_id;
  logic        pc_redirect;
  logic [29:0] redirect_pc;
  logic        in_handler;
  logic [1:0]  state_dbg;
`ifdef CP0_INT_CNT_EN
  logic [CW-1:0] int_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: redirect targets the model expects, in order.
  logic [29:0] exp_q[$];

  cp0_int_seq #(.HANDLER_VEC(HVEC), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .int_req     (int_req),
    .id_valid    (id_valid),
    .id_eret     (id_eret),
    .ex_busy     (ex_busy),
    .mem_busy    (mem_busy),
    .epc         (epc),
    .cp0_ctrl    (cp0_ctrl),
    .stall_if    (stall_if),
    .flush_if    (flush_if),
    .flush_id    (flush_id),
    .pc_redirect (pc_redirect),
    .redirect_pc (redirect_pc),
    .in_handler  (in_handler),
`ifdef CP0_INT_CNT_EN
    .int_cnt     (int_cnt),
`endif
    .state_dbg   (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    int_req  = 1'b0;
    id_valid = 1'b0;
    id_eret  = 1'b0;
    ex_busy  = 1'b0;
    mem_busy = 1'b0;
  endtask

  task automatic apply_reset();
    quiet_inputs();
    #2 rst = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (stimulus only)
  // ---------------------------------------------------------------------------
  // Clean interrupt entry with no busy stages; this leaves the DUT in IDLE
  // with the handler active.
  task automatic do_entry();
    int_req = 1'b1; id_valid = 1'b1;
    step();          // DRAIN
    step();          // ENTER
    int_req = 1'b0; id_valid = 1'b0;
    step();          // IDLE
  endtask

  task automatic do_eret(input logic [29:0] target);
    epc = target; id_eret = 1'b1; id_valid = 1'b1;
    step();          // ERET
    id_eret = 1'b0; id_valid = 1'b0;
    step();          // IDLE
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [1:0] st_before;
    apply_reset();
    // Enter DRAIN and hold it there with ex_busy.
    int_req = 1'b1; id_valid = 1'b1; ex_busy = 1'b1;
    step();
    step();
    st_before = state_dbg;
    n_checks++;
    if (stall_if !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_drain: stall_if=%b expected 1 (state %0d)", stall_if, st_before);
    end
    // Assert reset mid-cycle: the outputs must clear without waiting for a clock edge.
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({cp0_ctrl, stall_if, flush_if, flush_id, pc_redirect} !== 6'b0 || redirect_pc !== 30'd0) begin
      n_fail++; $display("FAIL reset_outputs: ctrl=%b stall=%b fif=%b fid=%b redir=%b pc=%h expected all 0",
        cp0_ctrl, stall_if, flush_if, flush_id, pc_redirect, redirect_pc);
    end
    n_checks++;
    if (state_dbg !== 2'd0 || in_handler !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: state=%0d in_handler=%b expected 0/0", state_dbg, in_handler);
    end
`ifdef CP0_INT_CNT_EN
    n_checks++;
    if (int_cnt !== '0) begin
      n_fail++; $display("FAIL reset_cnt: int_cnt=%0d expected 0", int_cnt);
    end
`endif
    quiet_inputs();
    #2 rst = 1'b1;
    step();
    n_checks++;
    if (cp0_ctrl !== 2'b00 || stall_if !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: ctrl=%b stall=%b expected 00/0", cp0_ctrl, stall_if);
    end
  endtask

  task automatic test_clean_entry();
    int_req = 1'b1; id_valid = 1'b1;
    step();
    n_checks++;
    if (stall_if !== 1'b1 || cp0_ctrl !== 2'b00 || pc_redirect !== 1'b0) begin
      n_fail++; $display("FAIL entry_n1: stall=%b ctrl=%b redir=%b expected 1/00/0", stall_if, cp0_ctrl, pc_redirect);
    end
    step();
    n_checks++;
    if (cp0_ctrl !== 2'b10 || pc_redirect !== 1'b1 || redirect_pc !== 30'h1060 ||
        flush_if !== 1'b1 || flush_id !== 1'b1 || stall_if !== 1'b0) begin
      n_fail++; $display("FAIL entry_n2: ctrl=%b redir=%b pc=%h fif=%b fid=%b stall=%b expected 10/1/1060/1/1/0",
        cp0_ctrl, pc_redirect, redirect_pc, flush_if, flush_id, stall_if);
    end
    int_req = 1'b0; id_valid = 1'b0;
    step();
    n_checks++;
    if (in_handler !== 1'b1 || cp0_ctrl !== 2'b00 || pc_redirect !== 1'b0 || redirect_pc !== 30'd0) begin
      n_fail++; $display("FAIL entry_n3: in_handler=%b ctrl=%b redir=%b pc=%h expected 1/00/0/0",
        in_handler, cp0_ctrl, pc_redirect, redirect_pc);
    end
  endtask

  task automatic test_eret();
    epc = 30'h0000_0C05; id_eret = 1'b1; id_valid = 1'b1;
    step();
    n_checks++;
    if (cp0_ctrl !== 2'b01 || redirect_pc !== 30'h0000_0C05 || pc_redirect !== 1'b1 ||
        flush_if !== 1'b1 || flush_id !== 1'b0) begin
      n_fail++; $display("FAIL eret_n1: ctrl=%b pc=%h redir=%b fif=%b fid=%b expected 01/0c05/1/1/0",
        cp0_ctrl, redirect_pc, pc_redirect, flush_if, flush_id);
    end
    id_eret = 1'b0; id_valid = 1'b0;
    step();
    n_checks++;
    if (in_handler !== 1'b0 || cp0_ctrl !== 2'b00 || pc_redirect !== 1'b0) begin
      n_fail++; $display("FAIL eret_n2: in_handler=%b ctrl=%b redir=%b expected 0/00/0", in_handler, cp0_ctrl, pc_redirect);
    end
  endtask

  task automatic test_drain();
    int stalls;
    int guard;
    bit saw_enter;
    bit saw_set;
`ifdef CP0_INT_CNT_EN
    logic [CW-1:0] cnt_before;
`endif
    // MEM stays busy for four DRAIN cycles, then releases.
    stalls = 0; saw_enter = 1'b0; guard = 0;
    int_req = 1'b1; id_valid = 1'b1; mem_busy = 1'b1;
    while (!saw_enter && guard < 20) begin
      step();
      guard++;
      if (stall_if === 1'b1) stalls++;
      if (cp0_ctrl === 2'b10) saw_enter = 1'b1;
      if (stalls == 5) mem_busy = 1'b0;
    end
    n_checks++;
    if (!saw_enter || stalls != 5) begin
      n_fail++; $display("FAIL drain_len: entered=%0d stall_cycles=%0d expected 1/5", saw_enter, stalls);
    end
    int_req = 1'b0; id_valid = 1'b0;
    step();
    n_checks++;
    if (in_handler !== 1'b1) begin
      n_fail++; $display("FAIL drain_handler: in_handler=%b expected 1", in_handler);
    end
    do_eret(30'h0000_0123);

    // Spurious request: int_req drops on the second DRAIN cycle.
`ifdef CP0_INT_CNT_EN
    cnt_before = int_cnt;
`endif
    saw_set = 1'b0;
    int_req = 1'b1; id_valid = 1'b1; ex_busy = 1'b1;
    step();          // DRAIN 1
    step();          // DRAIN 2
    int_req = 1'b0; id_valid = 1'b0; ex_busy = 1'b0;
    step();
    n_checks++;
    if (stall_if !== 1'b0 || state_dbg !== 2'd0) begin
      n_fail++; $display("FAIL spurious_idle: stall=%b state=%0d expected 0/0", stall_if, state_dbg);
    end
    for (int i = 0; i < 4; i++) begin
      if (cp0_ctrl[1] === 1'b1) saw_set = 1'b1;
      step();
    end
    n_checks++;
    if (saw_set || in_handler !== 1'b0) begin
      n_fail++; $display("FAIL spurious_noentry: exlset_seen=%0d in_handler=%b expected 0/0", saw_set, in_handler);
    end
`ifdef CP0_INT_CNT_EN
    n_checks++;
    if (int_cnt !== cnt_before) begin
      n_fail++; $display("FAIL spurious_cnt: int_cnt=%0d expected %0d", int_cnt, cnt_before);
    end
`endif
  endtask

  task automatic test_lockout_ignore();
    bit bad;
    do_entry();
    // While in the handler, a pending interrupt must never start a drain.
    bad = 1'b0;
    int_req = 1'b1; id_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (stall_if !== 1'b0 || cp0_ctrl !== 2'b00) bad = 1'b1;
    end
    n_checks++;
    if (bad || in_handler !== 1'b1) begin
      n_fail++; $display("FAIL lockout: activity=%0d in_handler=%b expected 0/1", bad, in_handler);
    end
    int_req = 1'b0; id_valid = 1'b0;
    do_eret(30'h0000_0200);
    // Outside the handler, ERET must be ignored.
    bad = 1'b0;
    epc = 30'h0000_0777; id_eret = 1'b1; id_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if ({cp0_ctrl, stall_if, flush_if, flush_id, pc_redirect} !== 6'b0 || redirect_pc !== 30'd0) bad = 1'b1;
    end
    n_checks++;
    if (bad || in_handler !== 1'b0) begin
      n_fail++; $display("FAIL eret_ignored: activity=%0d in_handler=%b expected 0/0", bad, in_handler);
    end
    quiet_inputs();
  endtask

`ifdef CP0_INT_CNT_EN
  task automatic test_counter();
    logic [CW-1:0] want;
    apply_reset();
    for (int k = 1; k <= 4; k++) begin
      do_entry();
      want = CW'(k % 4);
      n_checks++;
      if (int_cnt !== want) begin
        n_fail++; $display("FAIL counter_%0d: int_cnt=%0d expected %0d", k, int_cnt, want);
      end
      do_eret(30'h0000_0040);
    end
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Randomized run against an event-level model. The model tracks only
  // "handler active", "draining", and "redirect due this cycle" flags, plus a
  // count of taken interrupts.
  // ---------------------------------------------------------------------------
  task automatic test_random();
    bit m_exl, m_drain, m_enter, m_eret;
    bit n_exl, n_drain, n_enter, n_eret;
    int m_cnt;
    int errs;
    logic [29:0] exp_pc;
    logic [29:0] got_pc;
    apply_reset();
    m_exl = 0; m_drain = 0; m_enter = 0; m_eret = 0; m_cnt = 0; errs = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      int_req  = ($urandom_range(0, 99) < 40);
      id_valid = ($urandom_range(0, 99) < 70);
      id_eret  = ($urandom_range(0, 99) < 25);
      ex_busy  = ($urandom_range(0, 99) < 35);
      mem_busy = ($urandom_range(0, 99) < 30);
      epc      = 30'($urandom);
      // Predict the situation after this clock edge.
      n_exl = m_exl; n_drain = 0; n_enter = 0; n_eret = 0;
      if (m_enter) begin
        n_exl = 1; m_cnt = m_cnt + 1;
      end else if (m_eret) begin
        n_exl = 0;
      end else if (m_drain) begin
        if (!int_req) n_drain = 0;
        else if (!ex_busy && !mem_busy) n_enter = 1;
        else n_drain = 1;
      end else if (id_valid && id_eret && m_exl) begin
        n_eret = 1;
      end else if (int_req && id_valid && !m_exl) begin
        n_drain = 1;
      end
      step();
      m_exl = n_exl; m_drain = n_drain; m_enter = n_enter; m_eret = n_eret;
      if (m_enter) exp_q.push_back(HVEC);
      if (m_eret)  exp_q.push_back(epc);
      n_checks++;
      if (stall_if !== m_drain || cp0_ctrl !== {m_enter, m_eret} ||
          flush_if !== (m_enter | m_eret) || flush_id !== m_enter ||
          pc_redirect !== (m_enter | m_eret) || in_handler !== m_exl ||
          (!pc_redirect && redirect_pc !== 30'd0)) begin
        n_fail++; errs++;
        if (errs < 10)
          $display("FAIL rand_ctl cyc=%0d: stall=%b ctrl=%b fif=%b fid=%b redir=%b inh=%b pc=%h expected %b/%b%b/%b/%b/%b/%b",
            cyc, stall_if, cp0_ctrl, flush_if, flush_id, pc_redirect, in_handler, redirect_pc,
            m_drain, m_enter, m_eret, m_enter | m_eret, m_enter, m_enter | m_eret, m_exl);
      end
      if (pc_redirect === 1'b1) begin
        got_pc = redirect_pc;
        exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 30'h3fff_ffff;
        n_checks++;
        if (got_pc !== exp_pc) begin
          n_fail++; errs++;
          if (errs < 10) $display("FAIL rand_target cyc=%0d: redirect_pc=%h expected %h", cyc, got_pc, exp_pc);
        end
      end
`ifdef CP0_INT_CNT_EN
      n_checks++;
      if (int_cnt !== CW'(m_cnt)) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_cnt cyc=%0d: int_cnt=%0d expected %0d", cyc, int_cnt, CW'(m_cnt));
      end
`endif
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rand_leftover: %0d redirects expected but not seen", exp_q.size());
    end
    quiet_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_clean_entry();
    test_eret();
    test_drain();
    test_lockout_ignore();
`ifdef CP0_INT_CNT_EN
    test_counter();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
